if_block: RTL

- Instruction-fetch stage plus the IF/ID pipeline register, directly upstream of the decode stage.
- Maintains the fetch PC and issues one-outstanding requests to instruction memory over a req/ready + valid handshake.
- Delivers the 32-bit instruction, PC+4 and a valid flag to decode.
- Honours hazard-unit stall/flush and branch redirects from EX, discarding wrong-path responses.

---
 rtl/if_block.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/if_block.sv
// Instruction-fetch stage with IF/ID pipeline register: one outstanding imem
// request, stall/flush from the hazard unit and branch redirects from EX.
module if_block #(
  parameter int               WIDTH    = 64,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             p_clk,
  input  logic             p_reset_l,
  input  logic             p_Stall,
  input  logic             p_Flush,
  input  logic             p_Branch_Taken,
  input  logic [WIDTH-1:0] p_Branch_Target,
  output logic [WIDTH-1:0] p_IMEM_Addr,
  output logic             p_IMEM_Req,
  input  logic             p_IMEM_Ready,
  input  logic             p_IMEM_Valid,
  input  logic [31:0]      p_IMEM_Data,
  output logic [WIDTH-1:0] p_ID_IN_Instruction,
  output logic [WIDTH-1:0] p_ID_PC_Plus4,
  output logic             p_ID_Valid
);

  typedef enum logic [1:0] {
    ST_RST,
    ST_REQ,
    ST_WAIT,
    ST_HOLD
  } state_t;

  localparam logic [WIDTH-1:0] PC_STEP = WIDTH'(4);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] reqPc_q, reqPc_d;
  logic             discard_q, discard_d;
  logic [31:0]      holdData_q, holdData_d;
  logic [WIDTH-1:0] holdPc_q, holdPc_d;
  logic [31:0]      idInstr_q, idInstr_d;
  logic [WIDTH-1:0] idPcPlus4_q, idPcPlus4_d;
  logic             idValid_q, idValid_d;

  logic             imemReq;
  logic             load;
  logic [31:0]      loadData;
  logic [WIDTH-1:0] loadPc;

  always_ff @(posedge p_clk or negedge p_reset_l) begin
    if (!p_reset_l) begin
      state_q     <= ST_RST;
      pc_q        <= RESET_PC;
      reqPc_q     <= '0;
      discard_q   <= 1'b0;
      holdData_q  <= '0;
      holdPc_q    <= '0;
      idInstr_q   <= '0;
      idPcPlus4_q <= '0;
      idValid_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      reqPc_q     <= reqPc_d;
      discard_q   <= discard_d;
      holdData_q  <= holdData_d;
      holdPc_q    <= holdPc_d;
      idInstr_q   <= idInstr_d;
      idPcPlus4_q <= idPcPlus4_d;
      idValid_q   <= idValid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    reqPc_d     = reqPc_q;
    discard_d   = discard_q;
    holdData_d  = holdData_q;
    holdPc_d    = holdPc_q;
    idInstr_d   = idInstr_q;
    idPcPlus4_d = idPcPlus4_q;
    idValid_d   = idValid_q;
    imemReq     = 1'b0;
    load        = 1'b0;
    loadData    = p_IMEM_Data;
    loadPc      = reqPc_q;

    case (state_q)
      ST_RST: state_d = ST_REQ;
      ST_REQ: begin
        imemReq = 1'b1;
        if (p_IMEM_Ready) begin
          reqPc_d = pc_q;
          pc_d    = pc_q + PC_STEP;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (p_IMEM_Valid) begin
          if (discard_q) begin
            discard_d = 1'b0;
            state_d   = ST_REQ;
          end else if (!p_Stall) begin
            load    = 1'b1;
            state_d = ST_REQ;
          end else begin
            holdData_d = p_IMEM_Data;
            holdPc_d   = reqPc_q;
            state_d    = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (!p_Stall) begin
          load     = 1'b1;
          loadData = holdData_q;
          loadPc   = holdPc_q;
          state_d  = ST_REQ;
        end
      end
      default: state_d = ST_RST;
    endcase

    // A redirect overrides everything: whatever is in flight belongs to the old path.
    if (p_Branch_Taken) begin
      load       = 1'b0;
      pc_d       = p_Branch_Target & ~WIDTH'(3);
      holdData_d = holdData_q;
      holdPc_d   = holdPc_q;
      case (state_q)
        ST_REQ: begin
          if (p_IMEM_Ready) begin
            discard_d = 1'b1;
            state_d   = ST_WAIT;
          end
        end
        ST_WAIT: begin
          discard_d = !p_IMEM_Valid;
          state_d   = p_IMEM_Valid ? ST_REQ : ST_WAIT;
        end
        default: state_d = ST_REQ;
      endcase
    end

    if (p_Branch_Taken || p_Flush) begin
      idInstr_d = '0;
      idValid_d = 1'b0;
    end else if (load) begin
      idInstr_d   = loadData;
      idPcPlus4_d = loadPc + PC_STEP;
      idValid_d   = 1'b1;
    end else if (!p_Stall) begin
      idInstr_d = '0;
      idValid_d = 1'b0;
    end
  end

  assign p_IMEM_Req          = imemReq;
  assign p_IMEM_Addr         = pc_q;
  assign p_ID_IN_Instruction = WIDTH'(idInstr_q);
  assign p_ID_PC_Plus4       = idPcPlus4_q;
  assign p_ID_Valid          = idValid_q;

endmodule
